// File: rtl/fft_pkg.sv
// Shared sizing, index width and FSM encoding for the FFT front end.
package fft_pkg;

    localparam int unsigned NUM_WORDS = 48;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned IDX_W     = 6;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/flex_counter.sv
// Free-running modulo counter; the flag marks an enabled count that wraps to zero.
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4,
    parameter int unsigned ROLLOVER_VAL = 15
) (
    input  logic clk,
    input  logic n_rst,
    input  logic count_enable_i,
    output logic rollover_flag_o
);

    localparam logic [NUM_CNT_BITS-1:0] LAST = NUM_CNT_BITS'(ROLLOVER_VAL);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (count_enable_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign rollover_flag_o = count_enable_i && (count_q == LAST);

endmodule

// File: rtl/stp_frame_unloader.sv
// Captures a completed serial-to-parallel frame and streams it out one word
// per valid/ready transfer, flagging frames that arrive while still busy.
module stp_frame_unloader #(
    parameter int unsigned NUM_WORDS = fft_pkg::NUM_WORDS,
    parameter int unsigned WORD_W    = fft_pkg::WORD_W
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        it_cnt_strobe,
    input  logic [NUM_WORDS*WORD_W-1:0] in_frame,
    input  logic                        out_ready,
    input  logic                        clear_overrun,
    output logic [WORD_W-1:0]           out_data,
    output logic                        out_valid,
    output logic [fft_pkg::IDX_W-1:0]   out_index,
    output logic                        frame_done,
    output logic                        busy,
    output logic                        overrun
);

    import fft_pkg::*;

    localparam int unsigned CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned IW    = IDX_W;
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_WORDS - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic            ovr_q, ovr_d;
    logic            capture_q;
    logic            frame_complete;
    logic            load;
    logic            xfer;
    logic            last_xfer;
    logic [WORD_W-1:0] buf_q [NUM_WORDS];

    flex_counter #(
        .NUM_CNT_BITS (CNT_W),
        .ROLLOVER_VAL (WORD_W - 1)
    ) u_strobe_cnt (
        .clk             (clk),
        .n_rst           (n_rst),
        .count_enable_i  (it_cnt_strobe),
        .rollover_flag_o (frame_complete)
    );

    assign xfer      = valid_q && out_ready;
    assign last_xfer = xfer && (idx_q == IDX_LAST);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        load    = 1'b0;
        ovr_d   = ovr_q && !clear_overrun;
        unique case (state_q)
            IDLE: begin
                if (capture_q) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (last_xfer) begin
                    // A frame landing on the final transfer is taken back-to-back.
                    done_d  = 1'b1;
                    idx_d   = '0;
                    if (capture_q) begin
                        load    = 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        idx_d = idx_q + 1'b1;
                    end
                    if (capture_q) begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            capture_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            capture_q <= frame_complete;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            for (int unsigned w = 0; w < NUM_WORDS; w++) begin
                buf_q[w] <= in_frame[w*WORD_W +: WORD_W];
            end
        end
    end

    assign out_data   = buf_q[idx_q];
    assign out_valid  = valid_q;
    assign out_index  = idx_q;
    assign frame_done = done_q;
    assign busy       = (state_q == STREAM);
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_stp_frame_unloader.sv
// Directed bench: bit-serial frame loading, streaming, stalls, overrun and reset.
`timescale 1ns/1ps
module tb_stp_frame_unloader;

    localparam int unsigned NW = 48;
    localparam int unsigned WW = 16;
    localparam int unsigned NEVER = 999;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              it_cnt_strobe;
    logic [NW*WW-1:0]  in_frame;
    logic              out_ready;
    logic              clear_overrun;
    logic [WW-1:0]     out_data;
    logic              out_valid;
    logic [5:0]        out_index;
    logic              frame_done;
    logic              busy;
    logic              overrun;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #1.25 clk = ~clk;

    stp_frame_unloader #(
        .NUM_WORDS (NW),
        .WORD_W    (WW)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .it_cnt_strobe (it_cnt_strobe),
        .in_frame      (in_frame),
        .out_ready     (out_ready),
        .clear_overrun (clear_overrun),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_index     (out_index),
        .frame_done    (frame_done),
        .busy          (busy),
        .overrun       (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Models the external shift registers: MSB-first, one bit of word (base+w) per strobe.
    task automatic send_bits(input logic [15:0] base, input int unsigned first, input int unsigned n);
        logic [15:0] word;
        for (int unsigned k = first; k < first + n; k++) begin
            @(negedge clk);
            it_cnt_strobe = 1'b1;
            @(posedge clk);
            #0.2;
            it_cnt_strobe = 1'b0;
            for (int unsigned w = 0; w < NW; w++) begin
                word = base + 16'(w);
                in_frame[w*WW +: WW] = {in_frame[w*WW +: WW-1], word[WW-1-k]};
            end
        end
    endtask

    // Called at the negedge where index 0 is first presented.
    task automatic stream_words(input logic [15:0] base, input int unsigned stall_at,
                                input int unsigned stall_len, input int unsigned stop_at,
                                input int unsigned ovr_from, input logic expect_reload);
        int unsigned e   = 0;
        int unsigned cyc = 0;
        logic [15:0] exp_w;
        while (e < stop_at && cyc < 200) begin
            exp_w = base + 16'(e);
            check("valid", 32'(out_valid), 32'd1);
            check("index", 32'(out_index), e);
            check("data", 32'(out_data), 32'(exp_w));
            check("busy", 32'(busy), 32'd1);
            check("overrun", 32'(overrun), 32'(e >= ovr_from));
            if (cyc > 0) check("frame_done_mid", 32'(frame_done), 32'd0);
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            @(posedge clk);
            if (out_ready) e++;
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        check("stream_timeout", 32'(cyc < 200), 32'd1);
        if (stop_at == NW) begin
            check("frame_done_end", 32'(frame_done), 32'd1);
            check("valid_end", 32'(out_valid), 32'(expect_reload));
            check("busy_end", 32'(busy), 32'(expect_reload));
            check("index_end", 32'(out_index), 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_index"}, 32'(out_index), 32'd0);
        check({tag, "_done"}, 32'(frame_done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    // Frame loaded; step to the edge that presents word 0 of base.
    task automatic await_capture(input logic [15:0] base);
        @(negedge clk);
        check("valid_pending", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("valid_latency", 32'(out_valid), 32'd1);
        check("first_data", 32'(out_data), 32'(base));
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst         = 1'b0;
        it_cnt_strobe = 1'b0;
        in_frame      = '0;
        out_ready     = 1'b1;
        clear_overrun = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        n_rst = 1'b1;

        // Full frame at full rate.
        send_bits(16'hA000, 0, 16);
        await_capture(16'hA000);
        stream_words(16'hA000, NEVER, 0, NW, NEVER, 1'b0);
        @(negedge clk);
        check("frame_done_once", 32'(frame_done), 32'd0);

        // Stall pattern 1-0-0-1.
        send_bits(16'hB000, 0, 16);
        await_capture(16'hB000);
        stream_words(16'hB000, 6, 2, NW, NEVER, 1'b0);

        // Second frame completes at index 20: dropped, overrun sticky.
        send_bits(16'hC000, 0, 16);
        await_capture(16'hC000);
        fork
            stream_words(16'hC000, NEVER, 0, NW, 21, 1'b0);
            begin
                repeat (3) @(negedge clk);
                send_bits(16'hD000, 0, 16);
            end
        join
        check("overrun_sticky", 32'(overrun), 32'd1);
        clear_overrun = 1'b1;
        @(negedge clk);
        clear_overrun = 1'b0;
        check("overrun_cleared", 32'(overrun), 32'd0);

        // Second frame completes on the final transfer edge: back-to-back.
        send_bits(16'hE000, 0, 16);
        await_capture(16'hE000);
        fork
            stream_words(16'hE000, NEVER, 0, NW, NEVER, 1'b1);
            begin
                repeat (30) @(negedge clk);
                send_bits(16'hF000, 0, 16);
            end
        join
        check("reload_data", 32'(out_data), 32'hF000);
        check("reload_overrun", 32'(overrun), 32'd0);
        stream_words(16'hF000, NEVER, 0, NW, NEVER, 1'b0);

        // Reset mid-stream, then mid-frame after 7 strobes.
        send_bits(16'h5000, 0, 16);
        await_capture(16'h5000);
        stream_words(16'h5000, NEVER, 0, 30, NEVER, 1'b0);
        check("pre_reset_index", 32'(out_index), 32'd30);
        n_rst = 1'b0;
        #0.3;
        check_reset_outputs("rst_stream");
        @(negedge clk);
        n_rst = 1'b1;
        send_bits(16'h7000, 0, 7);
        @(negedge clk);
        n_rst = 1'b0;
        #0.3;
        check_reset_outputs("rst_frame");
        @(negedge clk);
        n_rst = 1'b1;
        send_bits(16'h6000, 0, 15);
        @(negedge clk);
        check("no_early_frame", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("no_early_frame2", 32'(out_valid), 32'd0);
        send_bits(16'h6000, 15, 1);
        await_capture(16'h6000);
        stream_words(16'h6000, NEVER, 0, NW, NEVER, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
